// File: rtl/pos_cache_mu_arbiter_pkg.sv
// Shared types and default widths for the motion-update broadcast arbiter.
package pos_cache_mu_arb_pkg;

  localparam int unsigned NUM_REQ_DEF        = 4;
  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned CELL_ID_WIDTH_DEF  = 4;
  localparam int unsigned HOLDOFF_CYCLES_DEF = 3;
  localparam int unsigned COUNT_WIDTH_DEF    = 16;
  localparam int unsigned POS_WIDTH          = 3 * DATA_WIDTH_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HOLDOFF,
    ST_DONE
  } state_t;

  // Packed {posz, posy, posx} width for a given per-axis width.
  function automatic int unsigned pos_width(input int unsigned data_width);
    return 3 * data_width;
  endfunction

endpackage

// File: rtl/pos_cache_mu_arbiter_if.sv
// Requester handshake and cache broadcast bus of the motion-update arbiter.
interface pos_cache_mu_arbiter_if
  import pos_cache_mu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned CELL_ID_WIDTH = CELL_ID_WIDTH_DEF
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*3*DATA_WIDTH-1:0]    req_data;
  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0] req_dst_cell;
  logic [NUM_REQ-1:0]                 req_done;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               motion_update_enable;
  logic [3*DATA_WIDTH-1:0]            out_data;
  logic [3*CELL_ID_WIDTH-1:0]         out_data_dst_cell;
  logic                               out_data_valid;

  // Requesters and caches side.
  modport master (
    output req_valid, req_data, req_dst_cell, req_done,
    input  req_ready, motion_update_enable, out_data, out_data_dst_cell, out_data_valid
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_dst_cell, req_done,
    output req_ready, motion_update_enable, out_data, out_data_dst_cell, out_data_valid
  );

endinterface

// File: rtl/pos_cache_mu_arbiter_rr_arbiter_onehot.sv
// Round-robin one-hot grant; search begins one past the last granted index.
module rr_arbiter_onehot #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = PTR_W'((int'(ptr) + k) % int'(NUM_REQ));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pos_cache_mu_arbiter.sv
// Motion-update broadcast arbiter: round-robin grant, drain, holdoff, done pulse.
// Optional particle counter built when POS_CACHE_MU_ARB_COUNT_EN is defined.
module pos_cache_mu_arbiter
  import pos_cache_mu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned CELL_ID_WIDTH  = CELL_ID_WIDTH_DEF,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int unsigned COUNT_WIDTH    = COUNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  pos_cache_mu_arbiter_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] total_count
);

  localparam int unsigned PW   = pos_width(DATA_WIDTH);
  localparam int unsigned CW   = 3 * CELL_ID_WIDTH;
  localparam int unsigned HC_W = $clog2(HOLDOFF_CYCLES);

  state_t            state, state_n;
  logic [HC_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0] arb_req, grant;
  logic              xfer, exit_c;
  logic [PW-1:0]     sel_data;
  logic [CW-1:0]     sel_dst;

  assign arb_req       = (state == ST_RUN) ? bus.req_valid : '0;
  assign xfer          = |grant;
  assign bus.req_ready = grant;
  assign exit_c        = (&bus.req_done) && !(|bus.req_valid);

  rr_arbiter_onehot #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (xfer),
    .grant   (grant)
  );

  // Select the granted requester's slice; grant is one-hot so OR-ing is safe.
  always_comb begin
    sel_data = '0;
    sel_dst  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_data = sel_data | bus.req_data[i*PW +: PW];
        sel_dst  = sel_dst  | bus.req_dst_cell[i*CW +: CW];
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (start) state_n = ST_RUN;
      ST_RUN:     if (exit_c) state_n = ST_DRAIN;
      ST_DRAIN:   state_n = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt == HC_W'(HOLDOFF_CYCLES - 1)) state_n = ST_DONE;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= (state == ST_HOLDOFF) ? hold_cnt + HC_W'(1) : '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.motion_update_enable <= 1'b0;
      bus.out_data_valid       <= 1'b0;
      bus.out_data             <= '0;
      bus.out_data_dst_cell    <= '0;
      busy                     <= 1'b0;
      done                     <= 1'b0;
    end else begin
      bus.motion_update_enable <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      bus.out_data_valid       <= xfer;
      bus.out_data             <= xfer ? sel_data : '0;
      bus.out_data_dst_cell    <= xfer ? sel_dst : '0;
      busy                     <= state_n inside {ST_RUN, ST_DRAIN, ST_HOLDOFF};
      done                     <= (state_n == ST_DONE);
    end
  end

`ifdef POS_CACHE_MU_ARB_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      total_count <= '0;
    end else if (xfer && (total_count != '1)) begin
      total_count <= total_count + COUNT_WIDTH'(1);
    end
  end
`else
  assign total_count = '0;
`endif

endmodule

// File: tb/tb_pos_cache_mu_arbiter.sv
// Scenario-table bench for pos_cache_mu_arbiter with a pass-level event model.
module tb_pos_cache_mu_arbiter;
  import pos_cache_mu_arb_pkg::*;

  localparam int NR   = 4;
  localparam int DW   = 32;
  localparam int CIW  = 4;
  localparam int H    = 3;
  localparam int CNTW = 16;
  localparam int PW   = 3 * DW;
  localparam int CW   = 3 * CIW;

  logic clk = 1'b0;
  logic rst_n, start, busy, done;
  logic [CNTW-1:0] total_count;

  pos_cache_mu_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CELL_ID_WIDTH(CIW)) bus ();

  pos_cache_mu_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .CELL_ID_WIDTH(CIW),
    .HOLDOFF_CYCLES(H), .COUNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .total_count(total_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0][7:0] q;        // particles per requester
    int  stall_req;               // requester idled during cycles 3..5, -1 none
    bit  start_mid;               // extra start pulse while running
    bit  rnd;                     // random counts and random valid gaps
    bit  fixed_dst;               // requester 0 uses dst {2,1,3}
    int  exp_total;               // broadcasts expected, -1 = don't care
    int  exp_en;                  // enable-high cycles expected, -1 = don't care
    int  exp_gaps;                // idle slots between broadcasts, -1 = don't care
  } vec_t;

  vec_t tbl[8];
  int n_pass = 0, n_chk = 0;
  int last_g;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (((v >> idx) & NR'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic run_pass(input vec_t v, input string nm);
    int q[NR];
    int sent[NR];
    int exit_c = 0, trc = 0, en_cnt = 0, vcount = 0, first_v = 0, last_v = 0, done_c = 0, pick;
    bit exit_found = 0, pend = 0, fin = 0, in_run, exp_en, exp_busy, exp_done, stalled, hold;
    logic [PW-1:0] pdata = '0;
    logic [CW-1:0] pdst = '0;
    logic [NR-1:0] exp_ready;
    logic [CNTW-1:0] exp_cnt;
    for (int i = 0; i < NR; i++) begin
      q[i]    = v.rnd ? int'($urandom_range(0, 6)) : int'(v.q[i]);
      sent[i] = 0;
    end
    for (int cyc = 0; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      exp_en   = (cyc >= 1) && (!exit_found || cyc <= exit_c + 1);
      exp_busy = (cyc >= 1) && (!exit_found || cyc <= exit_c + 1 + H);
      exp_done = exit_found && (cyc == exit_c + 2 + H);
`ifdef POS_CACHE_MU_ARB_COUNT_EN
      exp_cnt = CNTW'(trc);
`else
      exp_cnt = '0;
`endif
      chk({nm, " enable"}, 128'(bus.motion_update_enable), 128'(exp_en));
      chk({nm, " busy"}, 128'(busy), 128'(exp_busy));
      chk({nm, " done"}, 128'(done), 128'(exp_done));
      chk({nm, " out_valid"}, 128'(bus.out_data_valid), 128'(pend));
      chk({nm, " out_data"}, 128'(bus.out_data), 128'(pend ? pdata : '0));
      chk({nm, " out_dst"}, 128'(bus.out_data_dst_cell), 128'(pend ? pdst : '0));
      if (cyc >= 1) chk({nm, " total_count"}, 128'(total_count), 128'(exp_cnt));
      if (bus.motion_update_enable) en_cnt++;
      if (bus.out_data_valid) begin
        if (vcount == 0) first_v = cyc;
        last_v = cyc;
        vcount++;
      end
      if (exp_done) begin
        done_c = cyc;
        fin    = 1;
      end
      // Drive requesters for this cycle.
      start = (cyc == 0) || (v.start_mid && cyc == 2);
      for (int i = 0; i < NR; i++) begin
        stalled = (v.stall_req == i) && (cyc >= 3) && (cyc <= 5);
        hold    = v.rnd && ($urandom_range(0, 2) == 0);
        bus.req_valid[i] = (sent[i] < q[i]) && !stalled && !hold;
        bus.req_done[i]  = (sent[i] >= q[i]);
        bus.req_dst_cell[i*CW +: CW] = CW'($urandom());
        for (int a = 0; a < 3; a++) bus.req_data[(i*3+a)*DW +: DW] = $urandom();
      end
      if (v.fixed_dst) bus.req_dst_cell[CW-1:0] = {4'd2, 4'd1, 4'd3};
      #1;
      in_run = (cyc >= 1) && !exit_found;
      if (in_run && (&bus.req_done) && !(|bus.req_valid)) begin
        exit_found = 1;
        exit_c     = cyc;
      end
      pick      = in_run ? rr_pick(bus.req_valid, last_g) : -1;
      exp_ready = (pick >= 0) ? (NR'(1) << pick) : '0;
      chk({nm, " req_ready"}, 128'(bus.req_ready), 128'(exp_ready));
      pend = (pick >= 0);
      if (pend) begin
        pdata = bus.req_data[pick*PW +: PW];
        pdst  = bus.req_dst_cell[pick*CW +: CW];
        sent[pick]++;
        trc++;
        last_g = pick;
      end
    end
    start = 1'b0;
    chk({nm, " finished"}, 128'(fin), 128'(1));
    if (v.exp_total >= 0) chk({nm, " broadcasts"}, 128'(vcount), 128'(v.exp_total));
    if (v.exp_en >= 0) chk({nm, " enable_cycles"}, 128'(en_cnt), 128'(v.exp_en));
    if (v.exp_gaps >= 0 && vcount > 0)
      chk({nm, " gaps"}, 128'((last_v - first_v + 1) - vcount), 128'(v.exp_gaps));
    if (fin && vcount > 0) chk({nm, " done_latency"}, 128'(done_c - last_v), 128'(H + 2));
  endtask

  initial begin
    tbl[0] = '{q: {8'd2, 8'd2, 8'd2, 8'd2}, stall_req: -1, start_mid: 0, rnd: 0, fixed_dst: 0,
               exp_total: 8, exp_en: 10, exp_gaps: 0};
    tbl[1] = '{q: {8'd0, 8'd0, 8'd0, 8'd5}, stall_req: -1, start_mid: 0, rnd: 0, fixed_dst: 1,
               exp_total: 5, exp_en: 7, exp_gaps: 0};
    tbl[2] = '{q: {8'd0, 8'd0, 8'd0, 8'd0}, stall_req: -1, start_mid: 0, rnd: 0, fixed_dst: 0,
               exp_total: 0, exp_en: 2, exp_gaps: 0};
    tbl[3] = '{q: {8'd1, 8'd3, 8'd2, 8'd1}, stall_req: -1, start_mid: 1, rnd: 0, fixed_dst: 0,
               exp_total: 7, exp_en: 9, exp_gaps: 0};
    tbl[4] = '{q: {8'd2, 8'd2, 8'd2, 8'd2}, stall_req: 1, start_mid: 0, rnd: 0, fixed_dst: 0,
               exp_total: 8, exp_en: 10, exp_gaps: 0};
    for (int i = 5; i < 8; i++)
      tbl[i] = '{q: '0, stall_req: -1, start_mid: 0, rnd: 1, fixed_dst: 0,
                 exp_total: -1, exp_en: -1, exp_gaps: -1};

    rst_n = 1'b0;
    start = 1'b0;
    bus.req_valid    = '0;
    bus.req_done     = '0;
    bus.req_data     = '0;
    bus.req_dst_cell = '0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 128'(bus.req_ready), 128'(0));
    chk("reset enable", 128'(bus.motion_update_enable), 128'(0));
    chk("reset out_valid", 128'(bus.out_data_valid), 128'(0));
    chk("reset out_data", 128'(bus.out_data), 128'(0));
    chk("reset out_dst", 128'(bus.out_data_dst_cell), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset total_count", 128'(total_count), 128'(0));
    rst_n  = 1'b1;
    last_g = NR - 1;

    for (int i = 0; i < 8; i++) run_pass(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a pass with requester 1 still holding a particle.
    @(negedge clk);
    start = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_done  = 4'b1101;
    @(negedge clk);
    start = 1'b0;
    #1 chk("midrst grant", 128'(bus.req_ready), 128'(4'b0010));
    @(negedge clk);
    chk("midrst valid_before", 128'(bus.out_data_valid), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst req_ready", 128'(bus.req_ready), 128'(0));
    chk("midrst enable", 128'(bus.motion_update_enable), 128'(0));
    chk("midrst out_valid", 128'(bus.out_data_valid), 128'(0));
    chk("midrst out_data", 128'(bus.out_data), 128'(0));
    chk("midrst out_dst", 128'(bus.out_data_dst_cell), 128'(0));
    chk("midrst busy", 128'(busy), 128'(0));
    chk("midrst done", 128'(done), 128'(0));
    chk("midrst total_count", 128'(total_count), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;
    last_g = NR - 1;
    run_pass(tbl[0], "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
